axi_rdata_drop_chs: RTL and testbench
=====================================

# axi_rdata_drop_chs

Read-data return channel between the memory controller's R channel and the AXI application/interconnect side of the MMU wrapper. Buffers memory read beats in a parametrised FIFO and forwards them as whole, non-interleaved bursts. It also queues multiple dropped (faulted or rejected) read requests and answers each with a full-length DECERR burst of `ARLEN+1` beats. The DECERR bursts are inserted only at burst boundaries, behind a registered, AXI-compliant output stage.

## Interface
- `BUF_SZ`, 256: data FIFO depth in beats, power of 2, ≥4
- `DROP_DEPTH`, 8: drop-request queue depth, power of 2, ≥2
- `ID_WID`, 8: RID/ARID width
- `DATA_WID`, 32: RDATA width, multiple of 32
- `USER_WID`, 2: RUSER/ARUSER width
- `POISON`, 32'hdead_dead: 32-bit pattern, replicated `DATA_WID/32` times on DECERR beats

Ports:
- `clk` in 1: single clock, all logic rising-edge
- `reset_` in 1: synchronous, active-low reset
- `in_rid`/`in_rdata`/`in_rresp`/`in_ruser`/`in_rlast` in ID_WID/DATA_WID/2/USER_WID/1: memory-side R beat
- `in_mrvalid` in 1, `out_mrready` out 1: memory-side handshake
- `out_rid`/`out_rdata`/`out_rresp`/`out_ruser`/`out_rlast` out ID_WID/DATA_WID/2/USER_WID/1: app-side R beat, registered
- `out_srvalid` out 1, `in_srready` in 1: app-side handshake
- `in_arid` in ID_WID, `in_aruser` in USER_WID, `in_arlen` in 8: attributes of the dropped request, sampled with `drop`
- `drop` in 1: one-cycle push of a drop request
- `drop_full` out 1: drop queue full
- `drop_overflow` out 1: sticky flag, set when `drop` arrives while `drop_full`; cleared only by reset
- `drop_done` out 1: one-cycle pulse on the handshake of the last DECERR beat of each drop burst
- `drop_pending` out $clog2(DROP_DEPTH)+1: number of queued drop requests not yet started

## Operation
- Data FIFO stores {ruser, rdata, rid, rlast, rresp}. `out_mrready = ~full`. Push when `in_mrvalid & out_mrready`.
- Drop queue stores {arid, aruser, arlen}. Push when `drop & ~drop_full`. If `drop & drop_full`, the request is discarded and `drop_overflow` is set.
- Output register loads a new beat when `~out_srvalid | in_srready` and the selected source has a beat. While stalled, `out_srvalid` and the payload hold stable.
- FSM states:
  - IDLE: if the drop queue is non-empty, pop it into `cur_{id,user,len}`, clear `beat_cnt`, and go to DROP. Otherwise, if the data FIFO is non-empty, go to DATA. Drop has priority at a burst boundary.
  - DATA: forward FIFO beats unchanged. After the beat with `rlast=1` is loaded into the output register, go to IDLE. A drop arriving during DATA is queued and never interleaved.
  - DROP: each load drives `out_rid=cur_id`, `out_ruser=cur_user`, `out_rresp=2'b11`, `out_rdata={DATA_WID/32{POISON}}`, and `out_rlast=(beat_cnt==cur_len)`. `beat_cnt` is 8 bits and increments per load. After the beat with `beat_cnt==cur_len` is loaded, go to IDLE. The burst is `cur_len+1` beats; `arlen=255` gives 256 beats with no wrap error.
- `drop_done` pulses in the cycle the last DECERR beat handshakes (`out_srvalid & in_srready & out_rlast` in DROP-origin beat).
- `drop_pending` counts pushes minus pops. A simultaneous push and pop leaves it unchanged.

## Timing
- Reset (`reset_=0` at a clock edge) clears the following by the next cycle: FIFOs emptied, FSM to IDLE, `out_srvalid=0`, all `out_r*`=0, `drop_done=0`, `drop_overflow=0`, `drop_pending=0`, `drop_full=0`. `out_mrready` is 1 after reset.
- Reset mid-burst discards all buffered beats and queued drops. No partial burst resumes.
- Latency from memory beat to output: ingress handshake at cycle N, `out_srvalid=1` at cycle N+2 (FIFO registered read plus output register).
- Latency from drop to output: `drop` at N with the system otherwise idle, first DECERR beat valid at N+2.
- Throughput is 1 beat/cycle in both DATA and DROP when `in_srready` is held 1. There is no bubble between back-to-back bursts from the same source, and at most 1 bubble on a DATA↔DROP switch.
- FIFO full: `out_mrready=0` in the same cycle `full` is seen. A simultaneous push and pop at full is not permitted, because ready is already low.
- `drop_full` is combinational from the occupancy count.

## Test plan
- Single mem burst: 4 beats, rid=3, rresp=OKAY, `in_srready=1` → 4 output beats with identical payload, rlast only on beat 4, first valid 2 cycles after the first ingress.
- Backpressure: 8-beat burst with `in_srready` toggled 1,0,0,1… → no beat lost or duplicated, payload stable while stalled. With BUF_SZ=4, `out_mrready` drops after 4+ buffered beats.
- Drop during DATA: `drop` (arid=5, arlen=3) during beat 2 of an 8-beat mem burst → all 8 mem beats, then 4 DECERR beats with rid=5, data 32'hdead_dead, rlast on the 4th, and a single `drop_done` pulse.
- Queued drops: three `drop` pulses (arlen=0,1,255), then DROP_DEPTH+1 pushes → bursts of 1, 2 and 256 beats, `drop_pending` 3→0, `drop_overflow`=1 after the excess push.
- Reset mid-burst: `reset_=0` during beat 3 of DECERR burst → next cycle `out_srvalid=0`, `drop_pending=0`, FIFO empty, and no further output.

Source files
------------

// File: rtl/axi_rdata_drop_chs.sv
// axi_rdata_drop_chs
//   Read-data return channel between the memory controller R channel and the
//   application side. Memory beats are buffered in a FIFO and forwarded as
//   whole, non-interleaved bursts. Dropped read requests are queued and each
//   is answered with an ARLEN+1 beat DECERR burst, inserted only at burst
//   boundaries, through a registered AXI-compliant output stage.
//
// Ports
//   clk, reset_             : clock, synchronous active-low reset
//   in_r*, in_mrvalid       : memory-side R beat and valid
//   out_mrready             : memory-side ready (low while data FIFO is full)
//   out_r*, out_srvalid     : registered application-side R beat and valid
//   in_srready              : application-side ready
//   in_arid/in_aruser/in_arlen, drop : dropped request attributes and push
//   drop_full               : drop queue full
//   drop_overflow           : sticky, a drop arrived while the queue was full
//   drop_done               : last DECERR beat of a drop burst handshakes
//   drop_pending            : drop requests queued but not yet started
module axi_rdata_drop_chs #(
    parameter int          BUF_SZ     = 256,
    parameter int          DROP_DEPTH = 8,
    parameter int          ID_WID     = 8,
    parameter int          DATA_WID   = 32,
    parameter int          USER_WID   = 2,
    parameter logic [31:0] POISON     = 32'hdead_dead
) (
    input  logic                          clk,
    input  logic                          reset_,
    input  logic [ID_WID-1:0]             in_rid,
    input  logic [DATA_WID-1:0]           in_rdata,
    input  logic [1:0]                    in_rresp,
    input  logic [USER_WID-1:0]           in_ruser,
    input  logic                          in_rlast,
    input  logic                          in_mrvalid,
    output logic                          out_mrready,
    output logic [ID_WID-1:0]             out_rid,
    output logic [DATA_WID-1:0]           out_rdata,
    output logic [1:0]                    out_rresp,
    output logic [USER_WID-1:0]           out_ruser,
    output logic                          out_rlast,
    output logic                          out_srvalid,
    input  logic                          in_srready,
    input  logic [ID_WID-1:0]             in_arid,
    input  logic [USER_WID-1:0]           in_aruser,
    input  logic [7:0]                    in_arlen,
    input  logic                          drop,
    output logic                          drop_full,
    output logic                          drop_overflow,
    output logic                          drop_done,
    output logic [$clog2(DROP_DEPTH):0]   drop_pending
);

    localparam int FAW = $clog2(BUF_SZ);
    localparam int QAW = $clog2(DROP_DEPTH);
    localparam int FEW = USER_WID + DATA_WID + ID_WID + 3;
    localparam int QEW = ID_WID + USER_WID + 8;
    localparam logic [DATA_WID-1:0] POISON_DATA = {(DATA_WID/32){POISON}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_DROP
    } state_t;

    // Data FIFO
    logic [FEW-1:0]      fifo_mem [BUF_SZ];
    logic [FAW-1:0]      f_wr_ptr;
    logic [FAW-1:0]      f_rd_ptr;
    logic [FAW:0]        f_count;
    logic                f_full;
    logic                f_empty;
    logic                f_push;
    logic                f_pop;
    logic [USER_WID-1:0] h_user;
    logic [DATA_WID-1:0] h_data;
    logic [ID_WID-1:0]   h_id;
    logic                h_last;
    logic [1:0]          h_resp;

    // Drop request queue
    logic [QEW-1:0]      drop_mem [DROP_DEPTH];
    logic [QAW-1:0]      q_wr_ptr;
    logic [QAW-1:0]      q_rd_ptr;
    logic [QAW:0]        q_count;
    logic                q_empty;
    logic                q_push;
    logic                q_pop;
    logic [ID_WID-1:0]   q_id;
    logic [USER_WID-1:0] q_user;
    logic [7:0]          q_len;

    // Sequencer
    state_t              state;
    logic [ID_WID-1:0]   cur_id;
    logic [USER_WID-1:0] cur_user;
    logic [7:0]          cur_len;
    logic [7:0]          beat_cnt;
    logic                out_is_drop;
    logic                load_ok;
    logic                start_drop;
    logic                cont_drop;
    logic                take_data;
    logic                drop_last;

    assign f_full      = (f_count == (FAW+1)'(BUF_SZ));
    assign f_empty     = (f_count == '0);
    assign out_mrready = ~f_full;
    assign f_push      = in_mrvalid & ~f_full;
    assign {h_user, h_data, h_id, h_last, h_resp} = fifo_mem[f_rd_ptr];

    assign drop_full    = (q_count == (QAW+1)'(DROP_DEPTH));
    assign q_empty      = (q_count == '0);
    assign q_push       = drop & ~drop_full;
    assign {q_id, q_user, q_len} = drop_mem[q_rd_ptr];
    assign drop_pending = q_count;

    // A boundary decision and the first beat of the chosen burst happen in
    // the same cycle, so back-to-back bursts from one source have no bubble.
    // Queued drops win over buffered data whenever the sequencer is idle.
    assign load_ok    = ~out_srvalid | in_srready;
    assign start_drop = (state == S_IDLE) & ~q_empty;
    assign cont_drop  = (state == S_DROP);
    assign take_data  = ((state == S_DATA) | ((state == S_IDLE) & q_empty)) & ~f_empty;
    assign f_pop      = load_ok & take_data;
    assign q_pop      = load_ok & start_drop;
    assign drop_last  = (beat_cnt == cur_len);

    assign drop_done = out_srvalid & in_srready & out_rlast & out_is_drop;

    // Storage arrays carry no reset; occupancy counters define validity.
    always_ff @(posedge clk) begin
        if (f_push) begin
            fifo_mem[f_wr_ptr] <= {in_ruser, in_rdata, in_rid, in_rlast, in_rresp};
        end
        if (q_push) begin
            drop_mem[q_wr_ptr] <= {in_arid, in_aruser, in_arlen};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            f_wr_ptr      <= '0;
            f_rd_ptr      <= '0;
            f_count       <= '0;
            q_wr_ptr      <= '0;
            q_rd_ptr      <= '0;
            q_count       <= '0;
            drop_overflow <= 1'b0;
        end else begin
            if (f_push) f_wr_ptr <= f_wr_ptr + 1'b1;
            if (f_pop)  f_rd_ptr <= f_rd_ptr + 1'b1;
            if (f_push & ~f_pop)      f_count <= f_count + 1'b1;
            else if (~f_push & f_pop) f_count <= f_count - 1'b1;

            if (q_push) q_wr_ptr <= q_wr_ptr + 1'b1;
            if (q_pop)  q_rd_ptr <= q_rd_ptr + 1'b1;
            if (q_push & ~q_pop)      q_count <= q_count + 1'b1;
            else if (~q_push & q_pop) q_count <= q_count - 1'b1;

            if (drop & drop_full) drop_overflow <= 1'b1;
        end
    end

    // Burst sequencer and registered output stage. A DECERR burst's first
    // beat is built straight from the queue head; beat_cnt then counts the
    // remaining beats, so ARLEN=255 ends at beat_cnt==255 without wrapping.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            state       <= S_IDLE;
            cur_id      <= '0;
            cur_user    <= '0;
            cur_len     <= '0;
            beat_cnt    <= '0;
            out_is_drop <= 1'b0;
            out_srvalid <= 1'b0;
            out_rid     <= '0;
            out_rdata   <= '0;
            out_rresp   <= '0;
            out_ruser   <= '0;
            out_rlast   <= 1'b0;
        end else if (load_ok) begin
            if (start_drop) begin
                cur_id      <= q_id;
                cur_user    <= q_user;
                cur_len     <= q_len;
                beat_cnt    <= 8'd1;
                out_is_drop <= 1'b1;
                out_srvalid <= 1'b1;
                out_rid     <= q_id;
                out_ruser   <= q_user;
                out_rresp   <= 2'b11;
                out_rdata   <= POISON_DATA;
                out_rlast   <= (q_len == 8'd0);
                state       <= (q_len == 8'd0) ? S_IDLE : S_DROP;
            end else if (cont_drop) begin
                beat_cnt    <= beat_cnt + 8'd1;
                out_is_drop <= 1'b1;
                out_srvalid <= 1'b1;
                out_rid     <= cur_id;
                out_ruser   <= cur_user;
                out_rresp   <= 2'b11;
                out_rdata   <= POISON_DATA;
                out_rlast   <= drop_last;
                state       <= drop_last ? S_IDLE : S_DROP;
            end else if (take_data) begin
                out_is_drop <= 1'b0;
                out_srvalid <= 1'b1;
                out_rid     <= h_id;
                out_ruser   <= h_user;
                out_rresp   <= h_resp;
                out_rdata   <= h_data;
                out_rlast   <= h_last;
                state       <= h_last ? S_IDLE : S_DATA;
            end else begin
                out_srvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_rdata_drop_chs.sv
// tb_axi_rdata_drop_chs
//   Self-checking bench for axi_rdata_drop_chs. Expected output beats are
//   kept in an ordered queue built from the burst rules: memory bursts pass
//   through unchanged, each accepted drop becomes ARLEN+1 poison beats.
module tb_axi_rdata_drop_chs;

    localparam int BUF_SZ     = 4;
    localparam int DROP_DEPTH = 4;
    localparam int ID_WID     = 8;
    localparam int DATA_WID   = 64;
    localparam int USER_WID   = 2;
    localparam logic [31:0] POISON = 32'hdead_dead;
    localparam logic [63:0] POISON64 = {POISON, POISON};

    logic                        clk;
    logic                        reset_;
    logic [ID_WID-1:0]           in_rid;
    logic [DATA_WID-1:0]         in_rdata;
    logic [1:0]                  in_rresp;
    logic [USER_WID-1:0]         in_ruser;
    logic                        in_rlast;
    logic                        in_mrvalid;
    logic                        out_mrready;
    logic [ID_WID-1:0]           out_rid;
    logic [DATA_WID-1:0]         out_rdata;
    logic [1:0]                  out_rresp;
    logic [USER_WID-1:0]         out_ruser;
    logic                        out_rlast;
    logic                        out_srvalid;
    logic                        in_srready;
    logic [ID_WID-1:0]           in_arid;
    logic [USER_WID-1:0]         in_aruser;
    logic [7:0]                  in_arlen;
    logic                        drop;
    logic                        drop_full;
    logic                        drop_overflow;
    logic                        drop_done;
    logic [$clog2(DROP_DEPTH):0] drop_pending;

    typedef struct {
        logic [7:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic [1:0]  user;
        logic        last;
        logic        isDrop;
    } beat_t;

    beat_t memQ[$];
    beat_t expQ[$];

    int checks    = 0;
    int failures  = 0;
    int readyMode = 1;
    bit randomMem = 0;
    int cycleNo   = 0;
    int hsCount   = 0;
    int doneCount = 0;
    bit stallPrev = 0;
    logic [7:0]  prevId;
    logic [63:0] prevData;
    logic [1:0]  prevResp;
    logic [1:0]  prevUser;
    logic        prevLast;

    axi_rdata_drop_chs #(
        .BUF_SZ     (BUF_SZ),
        .DROP_DEPTH (DROP_DEPTH),
        .ID_WID     (ID_WID),
        .DATA_WID   (DATA_WID),
        .USER_WID   (USER_WID),
        .POISON     (POISON)
    ) dut (
        .clk           (clk),
        .reset_        (reset_),
        .in_rid        (in_rid),
        .in_rdata      (in_rdata),
        .in_rresp      (in_rresp),
        .in_ruser      (in_ruser),
        .in_rlast      (in_rlast),
        .in_mrvalid    (in_mrvalid),
        .out_mrready   (out_mrready),
        .out_rid       (out_rid),
        .out_rdata     (out_rdata),
        .out_rresp     (out_rresp),
        .out_ruser     (out_ruser),
        .out_rlast     (out_rlast),
        .out_srvalid   (out_srvalid),
        .in_srready    (in_srready),
        .in_arid       (in_arid),
        .in_aruser     (in_aruser),
        .in_arlen      (in_arlen),
        .drop          (drop),
        .drop_full     (drop_full),
        .drop_overflow (drop_overflow),
        .drop_done     (drop_done),
        .drop_pending  (drop_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive ready and the next memory beat, score any
    // output handshake against the expected queue, then advance.
    task automatic applyStimulus();
        beat_t e;
        case (readyMode)
            0:       in_srready = 1'b0;
            1:       in_srready = 1'b1;
            2:       in_srready = 1'($urandom_range(0, 1));
            default: in_srready = (cycleNo % 3 == 0);
        endcase
        if (memQ.size() > 0 && (!randomMem || $urandom_range(0, 3) != 0)) begin
            in_mrvalid = 1'b1;
            in_rid     = memQ[0].id;
            in_rdata   = memQ[0].data;
            in_rresp   = memQ[0].resp;
            in_ruser   = memQ[0].user;
            in_rlast   = memQ[0].last;
        end else begin
            in_mrvalid = 1'b0;
        end
        #1;
        if (stallPrev) begin
            checkOutput("stall_valid", 64'(out_srvalid), 64'd1);
            checkOutput("stall_rid",   64'(out_rid),   64'(prevId));
            checkOutput("stall_rdata", out_rdata,      prevData);
            checkOutput("stall_rresp", 64'(out_rresp), 64'(prevResp));
            checkOutput("stall_ruser", 64'(out_ruser), 64'(prevUser));
            checkOutput("stall_rlast", 64'(out_rlast), 64'(prevLast));
        end
        if (out_srvalid && in_srready) begin
            checkOutput("beat_expected", 64'(expQ.size() > 0), 64'd1);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("rid",       64'(out_rid),   64'(e.id));
                checkOutput("rdata",     out_rdata,      e.data);
                checkOutput("rresp",     64'(out_rresp), 64'(e.resp));
                checkOutput("ruser",     64'(out_ruser), 64'(e.user));
                checkOutput("rlast",     64'(out_rlast), 64'(e.last));
                checkOutput("drop_done", 64'(drop_done), 64'(e.isDrop && e.last));
            end
            hsCount++;
            if (drop_done) doneCount++;
        end else begin
            checkOutput("drop_done_quiet", 64'(drop_done), 64'd0);
        end
        if (in_mrvalid && out_mrready) void'(memQ.pop_front());
        stallPrev = out_srvalid && !in_srready;
        prevId    = out_rid;
        prevData  = out_rdata;
        prevResp  = out_rresp;
        prevUser  = out_ruser;
        prevLast  = out_rlast;
        @(posedge clk);
        @(negedge clk);
        in_mrvalid = 1'b0;
        drop       = 1'b0;
        cycleNo++;
    endtask

    task automatic makeBurst(input logic [7:0] id, input int len,
                             input logic [1:0] user, input bit randResp);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.id     = id;
            b.data   = {$urandom, $urandom};
            b.resp   = randResp ? 2'($urandom_range(0, 3)) : 2'b00;
            b.user   = user;
            b.last   = (i == len - 1);
            b.isDrop = 1'b0;
            memQ.push_back(b);
            expQ.push_back(b);
        end
    endtask

    // Pulses drop for one cycle; an accepted request expands to len+1 beats.
    task automatic issueDrop(input logic [7:0] id, input logic [1:0] user,
                             input logic [7:0] len, input bit accept);
        beat_t b;
        drop      = 1'b1;
        in_arid   = id;
        in_aruser = user;
        in_arlen  = len;
        if (accept) begin
            for (int i = 0; i <= int'(len); i++) begin
                b.id     = id;
                b.data   = POISON64;
                b.resp   = 2'b11;
                b.user   = user;
                b.last   = (i == int'(len));
                b.isDrop = 1'b1;
                expQ.push_back(b);
            end
        end
        applyStimulus();
    endtask

    task automatic drain(input string tag, input int maxCycles);
        int n = 0;
        while ((expQ.size() > 0 || memQ.size() > 0) && n < maxCycles) begin
            applyStimulus();
            n++;
        end
        checkOutput({tag, "_drained"}, 64'(expQ.size() == 0 && memQ.size() == 0), 64'd1);
        repeat (3) applyStimulus();
    endtask

    task automatic doReset(input string tag);
        reset_     = 1'b0;
        in_mrvalid = 1'b0;
        drop       = 1'b0;
        memQ.delete();
        expQ.delete();
        stallPrev  = 0;
        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput({tag, "_srvalid"},  64'(out_srvalid),   64'd0);
        checkOutput({tag, "_rid"},      64'(out_rid),       64'd0);
        checkOutput({tag, "_rdata"},    out_rdata,          64'd0);
        checkOutput({tag, "_rlast"},    64'(out_rlast),     64'd0);
        checkOutput({tag, "_pending"},  64'(drop_pending),  64'd0);
        checkOutput({tag, "_full"},     64'(drop_full),     64'd0);
        checkOutput({tag, "_overflow"}, 64'(drop_overflow), 64'd0);
        checkOutput({tag, "_done"},     64'(drop_done),     64'd0);
        checkOutput({tag, "_mrready"},  64'(out_mrready),   64'd1);
        reset_ = 1'b1;
    endtask

    initial begin
        int h0;
        int d0;
        int n;
        int pend;
        int attempts;
        int nDrops;
        logic [7:0] lens[5];

        reset_     = 1'b0;
        in_rid     = '0;
        in_rdata   = '0;
        in_rresp   = '0;
        in_ruser   = '0;
        in_rlast   = 1'b0;
        in_mrvalid = 1'b0;
        in_srready = 1'b0;
        in_arid    = '0;
        in_aruser  = '0;
        in_arlen   = '0;
        drop       = 1'b0;
        @(negedge clk);
        doReset("reset");

        $display("[TB] single memory burst and ingress latency");
        readyMode = 1;
        makeBurst(8'd3, 4, 2'd1, 0);
        applyStimulus();
        checkOutput("lat_mem_n1", 64'(out_srvalid), 64'd0);
        applyStimulus();
        checkOutput("lat_mem_n2", 64'(out_srvalid), 64'd1);
        drain("single", 50);

        $display("[TB] back-to-back data bursts");
        makeBurst(8'd1, 4, 2'd0, 1);
        makeBurst(8'd2, 4, 2'd3, 1);
        n = 0;
        while (!out_srvalid && n < 10) begin
            applyStimulus();
            n++;
        end
        h0 = hsCount;
        repeat (8) applyStimulus();
        checkOutput("b2b_throughput", 64'(hsCount - h0), 64'd8);
        drain("b2b", 50);

        $display("[TB] backpressure with full data FIFO");
        readyMode = 0;
        makeBurst(8'd4, 8, 2'd2, 1);
        repeat (8) applyStimulus();
        checkOutput("bp_mrready", 64'(out_mrready), 64'd0);
        checkOutput("bp_accepted", 64'(8 - memQ.size()), 64'(BUF_SZ + 1));
        readyMode = 3;
        drain("bp", 200);

        $display("[TB] drop latency");
        readyMode = 1;
        d0 = doneCount;
        issueDrop(8'd7, 2'd2, 8'd0, 1);
        checkOutput("lat_drop_n1", 64'(out_srvalid), 64'd0);
        applyStimulus();
        checkOutput("lat_drop_n2", 64'(out_srvalid), 64'd1);
        drain("drop_lat", 50);
        checkOutput("drop_lat_done", 64'(doneCount - d0), 64'd1);

        $display("[TB] drop during data burst");
        d0 = doneCount;
        makeBurst(8'h11, 8, 2'd1, 1);
        applyStimulus();
        applyStimulus();
        issueDrop(8'd5, 2'd1, 8'd3, 1);
        drain("mix", 100);
        checkOutput("mix_done_pulses", 64'(doneCount - d0), 64'd1);

        $display("[TB] queued drops and overflow");
        readyMode = 0;
        d0 = doneCount;
        issueDrop(8'h20, 2'd0, 8'd0, 1);
        lens[0] = 8'd0;
        lens[1] = 8'd1;
        lens[2] = 8'd255;
        lens[3] = 8'($urandom_range(0, 7));
        lens[4] = 8'($urandom_range(0, 7));
        pend = 0;
        attempts = 0;
        for (int i = 0; i < DROP_DEPTH + 1; i++) begin
            attempts++;
            issueDrop(8'(8'h21 + i), 2'(i), lens[i], pend < DROP_DEPTH);
            if (pend < DROP_DEPTH) pend++;
            if (i == 2) begin
                checkOutput("q_pending3", 64'(drop_pending), 64'(pend));
                checkOutput("q_notfull",  64'(drop_full),    64'(pend == DROP_DEPTH));
                checkOutput("q_noovf",    64'(drop_overflow), 64'(attempts > DROP_DEPTH));
            end
        end
        checkOutput("q_pending_full", 64'(drop_pending),  64'(pend));
        checkOutput("q_full",         64'(drop_full),     64'(pend == DROP_DEPTH));
        checkOutput("q_overflow",     64'(drop_overflow), 64'(attempts > DROP_DEPTH));
        readyMode = 1;
        drain("queued", 1000);
        checkOutput("q_done_pulses",  64'(doneCount - d0), 64'(pend + 1));
        checkOutput("q_pending_zero", 64'(drop_pending),   64'd0);
        checkOutput("q_ovf_sticky",   64'(drop_overflow),  64'd1);

        $display("[TB] random data bursts");
        readyMode = 2;
        randomMem = 1;
        for (int i = 0; i < 6; i++) begin
            makeBurst(8'($urandom), $urandom_range(1, 8), 2'($urandom_range(0, 3)), 1);
        end
        drain("rand_data", 600);
        randomMem = 0;

        $display("[TB] random drop bursts");
        for (int r = 0; r < 4; r++) begin
            d0 = doneCount;
            nDrops = $urandom_range(1, 3);
            for (int i = 0; i < nDrops; i++) begin
                issueDrop(8'($urandom), 2'($urandom_range(0, 3)),
                          8'($urandom_range(0, 15)), 1);
            end
            drain("rand_drop", 500);
            checkOutput("rand_drop_done", 64'(doneCount - d0), 64'(nDrops));
        end

        $display("[TB] reset in the middle of a drop burst");
        readyMode = 1;
        issueDrop(8'd9, 2'd3, 8'd7, 1);
        issueDrop(8'd10, 2'd0, 8'd2, 1);
        makeBurst(8'h33, 3, 2'd1, 1);
        repeat (3) applyStimulus();
        doReset("rst_mid");
        repeat (20) applyStimulus();
        checkOutput("rst_quiet_valid",   64'(out_srvalid),  64'd0);
        checkOutput("rst_quiet_pending", 64'(drop_pending), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
